hdmi_video_timing: RTL

Generates raster timing for the HDMI output path. It drives the `px_x`, `px_y` and `data_en` inputs of `hdmi_pixel_colour` and produces horizontal/vertical sync for the transmitter. It also provides sync/DE copies delayed to line up with the colour stage's registered RGB. It latches the operator channel selection once per frame so the displayed channel and its overlay digit never change mid-frame.

---
 rtl/hdmi_video_timing.sv | 133 +++++++++++++
 1 files changed

// File: rtl/hdmi_video_timing.sv
// Free-running raster timing generator: pixel position, syncs, data enable,
// a frame-stable channel latch and PIPE_DELAY-aligned sync/DE copies.
module hdmi_video_timing #(
    parameter int   H_ACTIVE   = 640,
    parameter int   H_FP       = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BP       = 48,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FP       = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 33,
    parameter logic HS_POL     = 1'b0,
    parameter logic VS_POL     = 1'b0,
    parameter int   PIPE_DELAY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  channel_req,
    output logic [11:0] px_x,
    output logic [11:0] px_y,
    output logic        data_en,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start,
    output logic [1:0]  channel_select,
    output logic        de_d,
    output logic        hsync_d,
    output logic        vsync_d
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // 13-bit constants so a full 4096-count axis still compares correctly.
    localparam logic [12:0] H_MAX    = 13'(H_TOTAL - 1);
    localparam logic [12:0] V_MAX    = 13'(V_TOTAL - 1);
    localparam logic [12:0] H_ACT    = 13'(H_ACTIVE);
    localparam logic [12:0] V_ACT    = 13'(V_ACTIVE);
    localparam logic [12:0] HS_START = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] HS_END   = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] VS_START = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] VS_END   = 13'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [2:0]  IDLE_SYNC = {1'b0, ~HS_POL, ~VS_POL};

    logic [11:0] h_cnt_q, h_cnt_d;
    logic [11:0] v_cnt_q, v_cnt_d;
    logic [12:0] h_ext, v_ext;

    logic [11:0] px_x_q, px_x_d;
    logic [11:0] px_y_q, px_y_d;
    logic        de_q, de_n;
    logic        hs_q, hs_n;
    logic        vs_q, vs_n;
    logic        fs_q, fs_n;
    logic [1:0]  ch_q, ch_d;

    assign h_ext = {1'b0, h_cnt_q};
    assign v_ext = {1'b0, v_cnt_q};

    always_comb begin
        h_cnt_d = h_cnt_q + 12'd1;
        v_cnt_d = v_cnt_q;
        if (h_ext == H_MAX) begin
            h_cnt_d = '0;
            v_cnt_d = (v_ext == V_MAX) ? 12'd0 : v_cnt_q + 12'd1;
        end
    end

    // Outputs are decoded from the position the counters hold before this edge.
    always_comb begin
        de_n   = (h_ext < H_ACT) && (v_ext < V_ACT);
        hs_n   = ((h_ext >= HS_START) && (h_ext < HS_END)) ? HS_POL : ~HS_POL;
        vs_n   = ((v_ext >= VS_START) && (v_ext < VS_END)) ? VS_POL : ~VS_POL;
        px_x_d = de_n ? h_cnt_q : 12'd0;
        px_y_d = de_n ? v_cnt_q : 12'd0;
        fs_n   = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
        ch_d   = fs_n ? channel_req : ch_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            px_x_q  <= '0;
            px_y_q  <= '0;
            de_q    <= 1'b0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            fs_q    <= 1'b0;
            ch_q    <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            px_x_q  <= px_x_d;
            px_y_q  <= px_y_d;
            de_q    <= de_n;
            hs_q    <= hs_n;
            vs_q    <= vs_n;
            fs_q    <= fs_n;
            ch_q    <= ch_d;
        end
    end

    assign px_x           = px_x_q;
    assign px_y           = px_y_q;
    assign data_en        = de_q;
    assign hsync          = hs_q;
    assign vsync          = vs_q;
    assign frame_start    = fs_q;
    assign channel_select = ch_q;

    // Delayed copies line up sync/DE with the colour stage's registered RGB.
    if (PIPE_DELAY == 0) begin : g_no_pipe
        assign de_d    = de_q;
        assign hsync_d = hs_q;
        assign vsync_d = vs_q;
    end else begin : g_pipe
        logic [2:0] pipe_q [PIPE_DELAY];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int i = 0; i < PIPE_DELAY; i++) pipe_q[i] <= IDLE_SYNC;
            end else begin
                pipe_q[0] <= {de_q, hs_q, vs_q};
                for (int i = 1; i < PIPE_DELAY; i++) pipe_q[i] <= pipe_q[i-1];
            end
        end

        assign {de_d, hsync_d, vsync_d} = pipe_q[PIPE_DELAY-1];
    end

endmodule
